// File: rtl/axi_pkg.sv
// Shared types and AXI constants for the round-robin AXI master.
package axi_pkg;

    // One transaction in flight: address phase, data phase, optional write response.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AxSIZE encoding for a full-width beat of width_bits.
    function automatic logic [2:0] axi_size(input int width_bits);
        return 3'($clog2(width_bits / 8));
    endfunction

    // Index width for n items; never zero so single-client builds still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, scanning upward with wrap.
module rr_arbiter
    import axi_pkg::*;
#(
    parameter int NCH = 3,
    localparam int PW = idx_width(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    input  logic           advance,
    output logic [NCH-1:0] grant,
    output logic [PW-1:0]  grant_idx
);

    logic          found;
    logic [PW-1:0] cand;

    // Walk the requesters starting at ptr; the first hit wins. No grant unless advance.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = PW'((32'(ptr) + 32'(i)) % NCH);
            if (advance && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axi_rr_master.sv
// AXI4 master serving NCH clients round-robin, one transaction outstanding.
module axi_rr_master
    import axi_pkg::*;
#(
    parameter int NCH       = 3,
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 16,
    parameter int IDW       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         req_valid,
    input  logic [NCH-1:0]         req_write,
    input  logic [NCH-1:0]         req_burst,
    input  logic [NCH*WIDTH-1:0]   req_addr,
    input  logic [NCH*WIDTH-1:0]   req_data,
    input  logic [NCH*WIDTH/8-1:0] req_mask,
    output logic [NCH-1:0]         req_ready,
    output logic [NCH-1:0]         resp_valid,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   resp_last,
    output logic                   resp_err,
    output logic [IDW-1:0]         axi_awid,
    output logic [WIDTH-1:0]       axi_awaddr,
    output logic [7:0]             axi_awlen,
    output logic [2:0]             axi_awsize,
    output logic [1:0]             axi_awburst,
    output logic                   axi_awvalid,
    input  logic                   axi_awready,
    output logic [WIDTH-1:0]       axi_wdata,
    output logic [WIDTH/8-1:0]     axi_wstrb,
    output logic                   axi_wlast,
    output logic                   axi_wvalid,
    input  logic                   axi_wready,
    input  logic [IDW-1:0]         axi_bid,
    input  logic [1:0]             axi_bresp,
    input  logic                   axi_bvalid,
    output logic                   axi_bready,
    output logic [IDW-1:0]         axi_arid,
    output logic [WIDTH-1:0]       axi_araddr,
    output logic [7:0]             axi_arlen,
    output logic [2:0]             axi_arsize,
    output logic [1:0]             axi_arburst,
    output logic                   axi_arvalid,
    input  logic                   axi_arready,
    input  logic [IDW-1:0]         axi_rid,
    input  logic [1:0]             axi_rresp,
    input  logic [WIDTH-1:0]       axi_rdata,
    input  logic                   axi_rlast,
    input  logic                   axi_rvalid,
    output logic                   axi_rready
);

    localparam int         PW          = idx_width(NCH);
    localparam int         SW          = WIDTH / 8;
    localparam logic [7:0] BURST_AXLEN = 8'(BURST_LEN - 1);
    localparam logic [2:0] AX_SIZE     = axi_size(WIDTH);

    state_t           state_reg, state_next;
    logic [PW-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0]    grant_reg, grant_next;
    logic [WIDTH-1:0] addr_reg, addr_next;
    logic [7:0]       len_reg, len_next;
    logic [7:0]       cnt_reg, cnt_next;

    logic [NCH-1:0]   arb_grant;
    logic [PW-1:0]    arb_idx;
    logic             any_grant;
    logic [IDW-1:0]   grant_id;

    logic [WIDTH-1:0] addr_slice [NCH];
    logic [WIDTH-1:0] data_slice [NCH];
    logic [SW-1:0]    mask_slice [NCH];

    // Unpack the per-client buses so the selected client is a plain array index.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
            assign addr_slice[gi] = req_addr[gi*WIDTH +: WIDTH];
            assign data_slice[gi] = req_data[gi*WIDTH +: WIDTH];
            assign mask_slice[gi] = req_mask[gi*SW +: SW];
        end
    endgenerate

    rr_arbiter #(
        .NCH       (NCH)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .advance   (state_reg == ST_IDLE),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign any_grant = |arb_grant;
    assign grant_id  = IDW'(grant_reg);

    // Address channels come straight from the latched request, so they stay stable while valid.
    assign axi_arid    = grant_id;
    assign axi_araddr  = addr_reg;
    assign axi_arlen   = len_reg;
    assign axi_arsize  = AX_SIZE;
    assign axi_arburst = AXI_BURST_INCR;
    assign axi_awid    = grant_id;
    assign axi_awaddr  = addr_reg;
    assign axi_awlen   = len_reg;
    assign axi_awsize  = AX_SIZE;
    assign axi_awburst = AXI_BURST_INCR;

    // Next-state and handshake logic; responses are combinational on the fire cycle.
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        grant_next  = grant_reg;
        addr_next   = addr_reg;
        len_next    = len_reg;
        cnt_next    = cnt_reg;
        axi_arvalid = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_wlast   = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_rready  = 1'b0;
        axi_bready  = 1'b0;
        req_ready   = '0;
        resp_valid  = '0;
        resp_data   = '0;
        resp_last   = 1'b0;
        resp_err    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (any_grant) begin
                    grant_next  = arb_idx;
                    addr_next   = addr_slice[arb_idx];
                    len_next    = req_burst[arb_idx] ? BURST_AXLEN : 8'd0;
                    cnt_next    = 8'd0;
                    rr_ptr_next = (32'(arb_idx) == NCH - 1) ? '0 : arb_idx + 1'b1;
                    state_next  = req_write[arb_idx] ? ST_AW : ST_AR;
                end
            end
            ST_AR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    cnt_next   = 8'd0;
                    state_next = ST_R;
                end
            end
            ST_R: begin
                axi_rready = 1'b1;
                if (axi_rvalid) begin
                    resp_valid[grant_reg] = 1'b1;
                    resp_data             = axi_rdata;
                    cnt_next              = cnt_reg + 8'd1;
                    // A short burst (rlast before the expected beat) is flagged and still ends it.
                    resp_err = (axi_rresp != AXI_RESP_OKAY) || (axi_rid != grant_id)
                             || (axi_rlast && (cnt_reg != len_reg));
                    if (axi_rlast) begin
                        resp_last  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_AW: begin
                axi_awvalid = 1'b1;
                if (axi_awready) begin
                    cnt_next   = 8'd0;
                    state_next = ST_W;
                end
            end
            ST_W: begin
                axi_wvalid = 1'b1;
                axi_wdata  = data_slice[grant_reg];
                axi_wstrb  = mask_slice[grant_reg];
                axi_wlast  = (cnt_reg == len_reg);
                if (axi_wready) begin
                    req_ready[grant_reg] = 1'b1;
                    cnt_next             = cnt_reg + 8'd1;
                    if (cnt_reg == len_reg) begin
                        state_next = ST_B;
                    end
                end
            end
            ST_B: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    resp_valid[grant_reg] = 1'b1;
                    resp_last             = 1'b1;
                    // A response tagged for another ID is treated like an error response.
                    resp_err   = (axi_bresp != AXI_RESP_OKAY) || (axi_bid != grant_id);
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and latched request fields; reset abandons any transaction without a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            rr_ptr_reg <= '0;
            grant_reg  <= '0;
            addr_reg   <= '0;
            len_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            grant_reg  <= grant_next;
            addr_reg   <= addr_next;
            len_reg    <= len_next;
            cnt_reg    <= cnt_next;
        end
    end

endmodule

// File: doc/axi_rr_master.md
# axi_rr_master

Parametrised AXI4 master that arbitrates `NCH` client request ports with round-robin fairness onto one AXI read/write port. It is the next generation of the single-fixed-priority cache/uncached AXI driver and sits between the core's memory clients (I$, D$, uncached, DMA) and the DDR AXI slave. It adds configurable client count, burst length and ID-tagged transactions. Per-client data streaming uses a beat-level ready handshake, and error reporting comes from RRESP/BRESP.

## Interface
Parameters:
- `NCH`, 3: number of client ports, 1..8.
- `WIDTH`, 32: client address and data width; equals `AXI_DATA_WIDTH`.
- `BURST_LEN`, 16: beats per burst transaction; power of two, 2..256.
- `IDW`, 4: AXI ID width; must satisfy `2**IDW >= NCH`.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NCH  per-client request pending; held high until completion.
- `req_write`  in  NCH  1 = write, 0 = read.
- `req_burst`  in  NCH  1 = `BURST_LEN`-beat burst, 0 = single beat.
- `req_addr`  in  NCH*WIDTH  packed start address.
- `req_data`  in  NCH*WIDTH  packed write data for the current beat.
- `req_mask`  in  NCH*WIDTH/8  packed write strobes for the current beat.
- `req_ready`  out  NCH  one-cycle pulse: the current write beat was consumed, so present the next beat.
- `resp_valid`  out  NCH  one-cycle pulse per read beat, and once at write completion.
- `resp_data`  out  WIDTH  read data; valid with `resp_valid`.
- `resp_last`  out  1  final response of the transaction.
- `resp_err`  out  1  RRESP/BRESP was non-zero, or a burst length mismatch occurred.
- AXI AW channel: `axi_awid`[IDW], `axi_awaddr`[WIDTH], `axi_awlen`[8], `axi_awsize`[3], `axi_awburst`[2], `axi_awvalid`; input `axi_awready`.
- AXI W channel: `axi_wdata`, `axi_wstrb`, `axi_wlast`, `axi_wvalid`; input `axi_wready`.
- AXI B channel: inputs `axi_bid`, `axi_bresp`, `axi_bvalid`; output `axi_bready`.
- AXI AR channel: `axi_arid`, `axi_araddr`, `axi_arlen`, `axi_arsize`, `axi_arburst`, `axi_arvalid`; input `axi_arready`.
- AXI R channel: inputs `axi_rid`, `axi_rresp`, `axi_rdata`, `axi_rlast`, `axi_rvalid`; output `axi_rready`.

## Operation
- One transaction is outstanding at a time. States: IDLE, AR, R, AW, W, B.
- **IDLE.** If any `req_valid` bit is set:
  - Grant the first requesting client at or after `rr_ptr`, scanning upward with wrap.
  - Latch grant index, write flag, burst flag and address.
  - Set `rr_ptr` to grant+1, mod NCH.
  - Go to AW if write, else AR.
- **AR.** `arvalid` = 1. `arid` = grant. `arlen` = burst ? `BURST_LEN`-1 : 0. `arsize` = log2(WIDTH/8). `arburst` = INCR. On `ar_fire`, go to R.
- **R.** `rready` = 1.
  - Each `r_fire` pulses `resp_valid[grant]` with `rdata`.
  - A beat counter increments on each `r_fire`.
  - On `r_fire && rlast`: assert `resp_last` and return to IDLE.
  - `resp_err` on a beat = (`rresp` != 0) or (`rlast` arrived with counter != `arlen`).
  - `rlast` arriving with counter != `arlen` also terminates the transaction.
  - `rid` != grant: the beat is still accepted and `resp_err` is raised on it.
- **AW.** Same fields as AR. On `aw_fire`, go to W with beat counter = 0.
- **W.** `wvalid` = 1. `wdata`/`wstrb` are muxed live from the granted client slice.
  - `wlast` = (counter == `awlen`).
  - Each `w_fire` pulses `req_ready[grant]` and increments the counter.
  - `w_fire && wlast` goes to B.
- **B.** `bready` = 1. On `b_fire`, pulse `resp_valid[grant]` with `resp_last` = 1 and `resp_err` = (`bresp` != 0), then go to IDLE.
- Write data is never presented before AW is accepted.
- Latched request fields do not track client changes after the grant. Only `req_data`/`req_mask` are sampled live.

## Timing
- Reset, while `rst_n` = 0 at a clock edge:
  - state IDLE, `rr_ptr` = 0;
  - all valid/ready/pulse outputs 0, counters 0;
  - address/len/id outputs 0.
- Reset mid-transaction aborts immediately. No response pulse is issued and the AXI valids drop in the next cycle.
- Grant latency: `req_valid` sampled at edge N, then `arvalid`/`awvalid` is high from cycle N+1.
- AXI valids remain asserted until their fire. Address, len and id are stable while valid.
- `resp_valid` is combinational on `r_fire`/`b_fire`, in the same cycle.
- At least one IDLE cycle separates consecutive transactions.
- Requests arriving in the completion cycle are arbitrated in the following IDLE cycle, using the already-advanced `rr_ptr`.
- Single-beat read: AR at N+1 and R data at the earliest N+2, so a minimum 3 cycles from request to response.

## Structure
- Package `axi_pkg`:
  - state enum;
  - AXI constants: burst type INCR = 2'b01, response OKAY = 2'b00;
  - `$clog2`-based size helpers.
- Sub-module `rr_arbiter` (parametrised NCH): inputs `req`, `ptr`, `advance`; outputs one-hot `grant` and `grant_idx`.
- All other logic lives in the top module.

## Test plan
- Single read: NCH=3, client 1 reads 0x8000_0040 single → `arid`=1, `arlen`=0; `rdata` 0xDEADBEEF returns as `resp_valid`=3'b010, `resp_last`=1, `resp_err`=0.
- Burst write: client 2 writes 16 beats at 0x1000 with slave `wready` toggling every other cycle → exactly 16 `req_ready[2]` pulses; `wlast` only on beat 15; one `resp_valid[2]` after B.
- Fairness: all 3 clients hold `req_valid` with single reads → grant order 0,1,2,0,1,2; no client is granted twice while another waits.
- Error: slave returns `rresp`=2'b10 on beat 5 of a 16-beat read → `resp_err`=1 only on beat 5; transaction completes after 16 beats.
- Early `rlast` on beat 7 of a 16-beat burst → transaction ends at beat 7 with `resp_err`=1, `resp_last`=1; state returns to IDLE.
- `rst_n` pulled low during W beat 4 → next cycle `wvalid`=0 and no `resp_valid`; after release, `rr_ptr`=0 and client 0 wins a simultaneous request.
